bcd_counter_n: RTL

Parametrised N-digit BCD up/down counter with synchronous load, wrap carry/borrow pulses and BCD-validity checking on load. Next-generation replacement for the fixed two-digit decimal counter. Intended for display front-ends (7-segment/LCD drivers) and decimal event tallies in `main`-level designs. Single clock domain; all outputs registered.

---
 rtl/bcd_counter_n.sv | 103 ++++++++++
 1 files changed

// File: rtl/bcd_counter_n.sv
`default_nettype none
// ============================================================================
// Module   : bcd_counter_n
// Brief    : N-digit BCD up/down counter with validated load and wrap pulses.
//            Define BCD_COUNTER_SATURATE_EN to saturate instead of wrapping.
// Revision : 1.0
// ============================================================================
module bcd_counter_n #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                count_en,
    input  logic                up,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_value,
    output logic [4*DIGITS-1:0] digits,
    output logic                carry,
    output logic                borrow,
    output logic                load_error
);

`ifdef BCD_COUNTER_SATURATE_EN
    localparam logic C_SATURATE = 1'b1;
`else
    localparam logic C_SATURATE = 1'b0;
`endif
    localparam logic [3:0] C_NINE = 4'd9;
    localparam logic [3:0] C_ZERO = 4'd0;

    logic [4*DIGITS-1:0] r_digits;
    logic                r_carry;
    logic                r_borrow;
    logic                r_load_error;

    logic [4*DIGITS-1:0] w_inc;
    logic [4*DIGITS-1:0] w_dec;
    logic [DIGITS:0]     w_inc_chain;
    logic [DIGITS:0]     w_dec_chain;
    logic [DIGITS-1:0]   w_nibble_ok;
    logic                w_load_ok;
    logic                w_all_nine;
    logic                w_all_zero;

    assign w_inc_chain[0] = 1'b1;
    assign w_dec_chain[0] = 1'b1;

    // Chain bit k is set when every digit below k is at its rollover value.
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic [3:0] w_cur;
        assign w_cur             = r_digits[4*k +: 4];
        assign w_inc_chain[k+1]  = w_inc_chain[k] & (w_cur == C_NINE);
        assign w_dec_chain[k+1]  = w_dec_chain[k] & (w_cur == C_ZERO);
        assign w_inc[4*k +: 4]   = !w_inc_chain[k]  ? w_cur :
                                   (w_cur == C_NINE) ? C_ZERO : w_cur + 4'd1;
        assign w_dec[4*k +: 4]   = !w_dec_chain[k]  ? w_cur :
                                   (w_cur == C_ZERO) ? C_NINE : w_cur - 4'd1;
        assign w_nibble_ok[k]    = (load_value[4*k +: 4] <= C_NINE);
    end

    assign w_load_ok  = &w_nibble_ok;
    assign w_all_nine = w_inc_chain[DIGITS];
    assign w_all_zero = w_dec_chain[DIGITS];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_digits     <= '0;
            r_carry      <= 1'b0;
            r_borrow     <= 1'b0;
            r_load_error <= 1'b0;
        end else begin
            r_carry      <= 1'b0;
            r_borrow     <= 1'b0;
            r_load_error <= 1'b0;
            if (load) begin
                if (w_load_ok) begin
                    r_digits <= load_value;
                end else begin
                    r_load_error <= 1'b1;
                end
            end else if (count_en) begin
                if (up) begin
                    if (!(w_all_nine && C_SATURATE)) begin
                        r_digits <= w_inc;
                    end
                    r_carry <= w_all_nine & ~C_SATURATE;
                end else begin
                    if (!(w_all_zero && C_SATURATE)) begin
                        r_digits <= w_dec;
                    end
                    r_borrow <= w_all_zero & ~C_SATURATE;
                end
            end
        end
    end

    assign digits     = r_digits;
    assign carry      = r_carry;
    assign borrow     = r_borrow;
    assign load_error = r_load_error;

endmodule
`default_nettype wire
